// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver and transmitter: frame size,
// default bit period and receiver state encoding.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 434;
    localparam int DATA_BITS            = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_START   = 3'd1;
    localparam state_t ST_DATA    = 3'd2;
    localparam state_t ST_STOP    = 3'd3;
    localparam state_t ST_CLEANUP = 3'd4;

endpackage

// File: rtl/uart_receiver_sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous bit; both flops
// load RESET_VAL on reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic D,
    output logic Q
);

    logic sync_p0;
    logic sync_p1;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            sync_p0 <= RESET_VAL;
            sync_p1 <= RESET_VAL;
        end else begin
            sync_p0 <= D;
            sync_p1 <= sync_p0;
        end
    end

    assign Q = sync_p1;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling of a synchronized serial line, one-cycle
// valid pulse per good byte and one-cycle error pulse per bad stop bit.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic                 RX_SERIAL,
    output logic [DATA_BITS-1:0] O_RX_BYTE,
    output logic                 O_RX_DATA_VALID,
    output logic                 O_RX_FRAME_ERROR,
    output logic                 O_RX_BUSY
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int IDX_W    = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    state_t               state;
    logic [CNT_W-1:0]     clk_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 rx_s;
    logic [1:0]           flush;
    logic                 armed;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_rx_sync (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .D    (RX_SERIAL),
        .Q    (rx_s)
    );

    // rx_s shows the synchronizer's reset value for two cycles; only a genuine
    // high seen after that arms start detection, so a line that is low across
    // a reset is not mistaken for a start bit.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state            <= ST_IDLE;
            clk_cnt          <= '0;
            bit_idx          <= '0;
            shift_reg        <= '0;
            flush            <= 2'b00;
            armed            <= 1'b0;
            O_RX_BYTE        <= '0;
            O_RX_DATA_VALID  <= 1'b0;
            O_RX_FRAME_ERROR <= 1'b0;
        end else begin
            O_RX_DATA_VALID  <= 1'b0;
            O_RX_FRAME_ERROR <= 1'b0;
            flush            <= {flush[0], 1'b1};
            if (rx_s && flush[1]) begin
                armed <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    clk_cnt <= '0;
                    if (!rx_s && armed) begin
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt            <= '0;
                        shift_reg[bit_idx] <= rx_s;
                        if (bit_idx == IDX_LAST) begin
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        state   <= ST_CLEANUP;
                        if (rx_s) begin
                            O_RX_BYTE       <= shift_reg;
                            O_RX_DATA_VALID <= 1'b1;
                        end else begin
                            O_RX_FRAME_ERROR <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                ST_CLEANUP: begin
                    // Hold here while the line stays low so a break cannot retrigger.
                    clk_cnt <= '0;
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    clk_cnt <= '0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign O_RX_BUSY = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: one instance at 434 clocks/bit, one at 8 clocks/bit,
// with a scoreboard of expected pulses per instance.
module tb_uart_receiver;

    typedef struct packed {
        logic       err;
        logic [7:0] b;
    } exp_t;

    typedef struct {
        int         sel;
        int         period;
        logic [7:0] data;
        logic       stopb;
        int         gap;
        logic       exp_err;
        logic [7:0] exp_byte;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_a, rx_a, vld_a, ferr_a, busy_a;
    logic       rst_b, rx_b, vld_b, ferr_b, busy_b;
    logic [7:0] byte_a, byte_b;

    int   total = 0;
    int   bad   = 0;
    int   na_v  = 0;
    int   nb_v  = 0;
    int   nb_e  = 0;
    logic pv_a  = 1'b0;
    logic pv_b  = 1'b0;
    exp_t sb_a[$];
    exp_t sb_b[$];
    exp_t ea, eb;
    vec_t vecs[6];

    always #5 clk = ~clk;

    uart_receiver #(.CLKS_PER_BIT(434)) dut_a (
        .CLOCK           (clk),
        .RESET           (rst_a),
        .RX_SERIAL       (rx_a),
        .O_RX_BYTE       (byte_a),
        .O_RX_DATA_VALID (vld_a),
        .O_RX_FRAME_ERROR(ferr_a),
        .O_RX_BUSY       (busy_a)
    );

    uart_receiver #(.CLKS_PER_BIT(8)) dut_b (
        .CLOCK           (clk),
        .RESET           (rst_b),
        .RX_SERIAL       (rx_b),
        .O_RX_BYTE       (byte_b),
        .O_RX_DATA_VALID (vld_b),
        .O_RX_FRAME_ERROR(ferr_b),
        .O_RX_BUSY       (busy_b)
    );

    task automatic check_eq(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%02h required=%02h", name, act, req);
        end
    endtask

    task automatic check_pulse(input string name, input logic v, input logic f,
                               input logic [7:0] b, input exp_t e);
        total++;
        if (v !== ~e.err || f !== e.err || b !== e.b) begin
            bad++;
            $display("FAIL %s actual valid=%0b err=%0b byte=%02h required valid=%0b err=%0b byte=%02h",
                     name, v, f, b, ~e.err, e.err, e.b);
        end
    endtask

    // Scoreboard: every pulse must match the oldest expectation for its instance.
    always @(negedge clk) begin
        if (vld_a || ferr_a) begin
            if (vld_a) na_v++;
            if (sb_a.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse_a actual valid=%0b err=%0b byte=%02h required=none",
                         vld_a, ferr_a, byte_a);
            end else begin
                ea = sb_a.pop_front();
                check_pulse("pulse_a", vld_a, ferr_a, byte_a, ea);
            end
            total++;
            if (pv_a) begin
                bad++;
                $display("FAIL pulse_width_a actual=2+ cycles required=1 cycle");
            end
        end
        pv_a = vld_a || ferr_a;
    end

    always @(negedge clk) begin
        if (vld_b || ferr_b) begin
            if (vld_b) nb_v++;
            if (ferr_b) nb_e++;
            if (sb_b.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse_b actual valid=%0b err=%0b byte=%02h required=none",
                         vld_b, ferr_b, byte_b);
            end else begin
                eb = sb_b.pop_front();
                check_pulse("pulse_b", vld_b, ferr_b, byte_b, eb);
            end
            total++;
            if (pv_b) begin
                bad++;
                $display("FAIL pulse_width_b actual=2+ cycles required=1 cycle");
            end
        end
        pv_b = vld_b || ferr_b;
    end

    task automatic drive_bit(input int sel, input logic v, input int period);
        if (sel == 0) rx_a = v;
        else          rx_b = v;
        repeat (period) @(negedge clk);
    endtask

    task automatic send_frame(input int sel, input int period, input logic [7:0] d, input logic stopb);
        drive_bit(sel, 1'b0, period);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i], period);
        drive_bit(sel, stopb, period);
    endtask

    task automatic expect_b(input logic err, input logic [7:0] b);
        exp_t e;
        e.err = err;
        e.b   = b;
        sb_b.push_back(e);
    endtask

    initial begin
        vecs[0] = '{0, 434, 8'hA5, 1'b1, 868, 1'b0, 8'hA5};
        vecs[1] = '{0, 421, 8'h55, 1'b1, 868, 1'b0, 8'h55};
        vecs[2] = '{0, 447, 8'hAA, 1'b1, 868, 1'b0, 8'hAA};
        vecs[3] = '{1, 8,   8'h00, 1'b1, 0,   1'b0, 8'h00};
        vecs[4] = '{1, 8,   8'hFF, 1'b1, 0,   1'b0, 8'hFF};
        vecs[5] = '{1, 8,   8'h3C, 1'b1, 24,  1'b0, 8'h3C};

        rst_a = 1'b1;
        rst_b = 1'b1;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        check_eq("reset_byte_a",  byte_a, 8'h00);
        check_eq("reset_valid_a", {7'd0, vld_a}, 8'h00);
        check_eq("reset_err_a",   {7'd0, ferr_a}, 8'h00);
        check_eq("reset_busy_a",  {7'd0, busy_a}, 8'h00);
        check_eq("reset_byte_b",  byte_b, 8'h00);
        check_eq("reset_valid_b", {7'd0, vld_b}, 8'h00);
        check_eq("reset_err_b",   {7'd0, ferr_b}, 8'h00);
        check_eq("reset_busy_b",  {7'd0, busy_b}, 8'h00);
        repeat (8) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            exp_t e;
            e.err = vecs[i].exp_err;
            e.b   = vecs[i].exp_byte;
            if (vecs[i].sel == 0) sb_a.push_back(e);
            else                  sb_b.push_back(e);
            send_frame(vecs[i].sel, vecs[i].period, vecs[i].data, vecs[i].stopb);
            if (vecs[i].sel == 0) rx_a = 1'b1;
            else                  rx_b = 1'b1;
            repeat (vecs[i].gap) @(negedge clk);
        end
        check_eq("busy_a_idle", {7'd0, busy_a}, 8'h00);
        check_eq("byte_b_after_b2b", byte_b, 8'h3C);

        // Three-cycle low glitch must fall back to idle without a pulse.
        rx_b = 1'b0;
        repeat (3) @(negedge clk);
        rx_b = 1'b1;
        repeat (16) @(negedge clk);
        check_eq("glitch_busy_b", {7'd0, busy_b}, 8'h00);
        expect_b(1'b0, 8'h5A);
        send_frame(1, 8, 8'h5A, 1'b1);
        rx_b = 1'b1;
        repeat (16) @(negedge clk);

        // Bad stop bit followed by a long break, then a normal frame.
        expect_b(1'b1, 8'h5A);
        send_frame(1, 8, 8'h81, 1'b0);
        repeat (19 * 8) @(negedge clk);
        check_eq("break_busy_b", {7'd0, busy_b}, 8'h01);
        check_eq("break_byte_held_b", byte_b, 8'h5A);
        rx_b = 1'b1;
        repeat (16) @(negedge clk);
        check_eq("break_release_busy_b", {7'd0, busy_b}, 8'h00);
        expect_b(1'b0, 8'h42);
        send_frame(1, 8, 8'h42, 1'b1);
        rx_b = 1'b1;
        repeat (16) @(negedge clk);

        // Reset pulse in the middle of data bit 4 of 0xC3 (line low there).
        fork
            send_frame(1, 8, 8'hC3, 1'b1);
            begin
                repeat (44) @(negedge clk);
                rst_b = 1'b1;
                @(negedge clk);
                rst_b = 1'b0;
                check_eq("midreset_byte_b", byte_b, 8'h00);
                check_eq("midreset_busy_b", {7'd0, busy_b}, 8'h00);
            end
        join
        rx_b = 1'b1;
        repeat (24) @(negedge clk);
        check_eq("post_reset_busy_b", {7'd0, busy_b}, 8'h00);
        check_eq("post_reset_byte_b", byte_b, 8'h00);
        expect_b(1'b0, 8'h99);
        send_frame(1, 8, 8'h99, 1'b1);
        rx_b = 1'b1;

        for (int i = 0; i < 5000 && (sb_a.size() != 0 || sb_b.size() != 0); i++) @(negedge clk);
        repeat (16) @(negedge clk);
        check_eq("sb_a_drained", 8'(sb_a.size()), 8'd0);
        check_eq("sb_b_drained", 8'(sb_b.size()), 8'd0);
        check_eq("valid_count_a", 8'(na_v), 8'd3);
        check_eq("valid_count_b", 8'(nb_v), 8'd6);
        check_eq("error_count_b", 8'(nb_e), 8'd1);
        check_eq("final_byte_b", byte_b, 8'h99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
